instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader.sv | 184 ++++++++++++++++++
 tb/tb_instr_loader.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// instr_loader: streams a big-endian program image (16-bit word count,
// then 4 bytes per word) from a byte valid/ready channel into the
// instruction memory write port, holding the CPU stalled via busy.
// Optional checksum trailer: compile with LOADER_CHECKSUM_EN defined.
//
// Handshake: a byte transfers on a rising edge where byte_valid and
// byte_ready are both high. byte_valid may drop at any time; byte_ready
// is high only in HDR0, HDR1, WORD and CHK.
module instr_loader #(
  parameter int INSTR_MEM_HEIGHT = 1024,
  parameter int ADDR_W           = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] a,
  output logic [31:0]       d,
  output logic              we,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR0  = 3'd1,
    HDR1  = 3'd2,
    WORD  = 3'd3,
    WRITE = 3'd4,
`ifdef LOADER_CHECKSUM_EN
    CHK   = 3'd5,
`endif
    DONE  = 3'd6,
    ERR   = 3'd7
  } state_t;

  state_t      state;
  logic [7:0]  count_hi;
  logic [15:0] count;
  logic [16:0] widx;
  logic [1:0]  bcnt;
  logic [23:0] asm_buf;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  logic        xfer;
  logic [15:0] hdr_count;

  // Handshake strobe and the header count as it completes in HDR1.
  always_comb begin
    xfer      = byte_valid & byte_ready;
    hdr_count = {count_hi, byte_in};
    state_dbg = state;
  end

  // Loader FSM; all outputs are registered and updated with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      byte_ready <= 1'b0;
      a          <= '0;
      d          <= '0;
      we         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      count_hi   <= '0;
      count      <= '0;
      widx       <= '0;
      bcnt       <= '0;
      asm_buf    <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state      <= HDR0;
            byte_ready <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            widx       <= '0;
            bcnt       <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
          end
        end
        HDR0: begin
          if (xfer) begin
            count_hi <= byte_in;
            state    <= HDR1;
          end
        end
        HDR1: begin
          if (xfer) begin
            count <= hdr_count;
            if (32'(hdr_count) > INSTR_MEM_HEIGHT) begin
              state      <= ERR;
              byte_ready <= 1'b0;
              busy       <= 1'b0;
              error      <= 1'b1;
            end else if (hdr_count == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
              state      <= CHK;
`else
              state      <= DONE;
              byte_ready <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
`endif
            end else begin
              state <= WORD;
            end
          end
        end
        WORD: begin
          if (xfer) begin
`ifdef LOADER_CHECKSUM_EN
            csum <= csum ^ byte_in;
`endif
            if (bcnt == 2'd3) begin
              // Fourth byte: present the whole word on the write port.
              state      <= WRITE;
              byte_ready <= 1'b0;
              we         <= 1'b1;
              a          <= widx[ADDR_W-1:0];
              d          <= {asm_buf, byte_in};
              bcnt       <= '0;
            end else begin
              asm_buf <= {asm_buf[15:0], byte_in};
              bcnt    <= bcnt + 2'd1;
            end
          end
        end
        WRITE: begin
          widx <= widx + 17'd1;
          if ((widx + 17'd1) < {1'b0, count}) begin
            state      <= WORD;
            byte_ready <= 1'b1;
          end else begin
`ifdef LOADER_CHECKSUM_EN
            state      <= CHK;
            byte_ready <= 1'b1;
`else
            state      <= DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
`endif
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CHK: begin
          if (xfer) begin
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            if (byte_in == csum) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state      <= IDLE;
          byte_ready <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Directed testbench for instr_loader; works with or without
// LOADER_CHECKSUM_EN (checksum trailers are sent only when defined).
module tb_instr_loader;

  localparam int ADDR_W = 10;

  logic              clk;
  logic              rst;
  logic              start;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic [ADDR_W-1:0] a;
  logic [31:0]       d;
  logic              we;
  logic              busy;
  logic              done;
  logic              error;
  logic [2:0]        state_dbg;

  int checks = 0;
  int errors = 0;

  logic [ADDR_W+31:0] exp_q[$];
  logic [ADDR_W+31:0] obs_q[$];

  instr_loader #(.INSTR_MEM_HEIGHT(1024), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .a(a), .d(d),
    .we(we), .busy(busy), .done(done), .error(error), .state_dbg(state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write-port monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (we === 1'b1) obs_q.push_back({a, d});
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic do_start();
    start = 1'b1;
    checks++;
    if (byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_at_start: got %b want 0", byte_ready);
    end
    @(negedge clk);
    start = 1'b0;
    obs_q.delete();
    exp_q.delete();
  endtask

  // Presents a byte and returns at the negedge after it transferred,
  // with byte_valid still high so calls can be chained back to back.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    while (byte_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: byte %h never accepted", b);
    end
    @(negedge clk);
  endtask

  task automatic gap();
    byte_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    byte_valid = 1'b0;
    while (!(done === 1'b1 || error === 1'b1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL end_timeout: neither done nor error raised");
    end
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks += 7;
    if (byte_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", byte_ready); end
    if (we !== 1'b0)         begin errors++; $display("FAIL rst_we: got %b want 0", we); end
    if (a !== '0)            begin errors++; $display("FAIL rst_a: got %h want 0", a); end
    if (d !== 32'h0)         begin errors++; $display("FAIL rst_d: got %h want 0", d); end
    if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    if (done !== 1'b0)       begin errors++; $display("FAIL rst_done: got %b want 0", done); end
    if (error !== 1'b0)      begin errors++; $display("FAIL rst_error: got %b want 0", error); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_word();
    do_start();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h20); send_byte(8'h01); send_byte(8'h00); send_byte(8'h0A);
    // Write is visible in the cycle right after the 4th byte edge.
    checks += 3;
    if (we !== 1'b1)            begin errors++; $display("FAIL single_we_latency: got %b want 1", we); end
    if (d !== 32'h2001000A)     begin errors++; $display("FAIL single_d_latency: got %h want 2001000a", d); end
    if (byte_ready !== 1'b0)    begin errors++; $display("FAIL single_ready_in_write: got %b want 0", byte_ready); end
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h2B);
`endif
    wait_end();
    exp_q.push_back({10'd0, 32'h2001000A});
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL single_nwrites: got %0d want %0d", obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL single_write%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
      end
    end
    checks += 4;
    if (done !== 1'b1)  begin errors++; $display("FAIL single_done: got %b want 1", done); end
    if (busy !== 1'b0)  begin errors++; $display("FAIL single_busy_end: got %b want 0", busy); end
    if (error !== 1'b0) begin errors++; $display("FAIL single_error: got %b want 0", error); end
    if (we !== 1'b0)    begin errors++; $display("FAIL single_we_idle: got %b want 0", we); end
  endtask

  task automatic test_stall();
    logic [7:0] pay[12];
    pay = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
            8'h99, 8'hAA, 8'hBB, 8'hCC};
    do_start();
    send_byte(8'h00); gap(); send_byte(8'h03); gap();
    for (int i = 0; i < 12; i++) begin
      send_byte(pay[i]);
      gap();
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'hCC);
`endif
    wait_end();
    exp_q.push_back({10'd0, 32'h11223344});
    exp_q.push_back({10'd1, 32'h55667788});
    exp_q.push_back({10'd2, 32'h99AABBCC});
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL stall_nwrites: got %0d want %0d", obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_write%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
      end
    end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL stall_done: got %b want 1", done); end
  endtask

  task automatic test_oversize();
    do_start();
    send_byte(8'h04); send_byte(8'h01);
    wait_end();
    checks += 6;
    if (error !== 1'b1)    begin errors++; $display("FAIL over_error: got %b want 1", error); end
    if (done !== 1'b0)     begin errors++; $display("FAIL over_done: got %b want 0", done); end
    if (busy !== 1'b0)     begin errors++; $display("FAIL over_busy: got %b want 0", busy); end
    if (obs_q.size() != 0) begin errors++; $display("FAIL over_nwrites: got %0d want 0", obs_q.size()); end
    // Last written a/d from the previous load are held.
    if (a !== 10'd2)       begin errors++; $display("FAIL over_hold_a: got %h want 2", a); end
    if (d !== 32'h99AABBCC) begin errors++; $display("FAIL over_hold_d: got %h want 99aabbcc", d); end
  endtask

  task automatic test_reset_mid_word();
    do_start();
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'hAA); send_byte(8'hBB);
    byte_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks += 6;
    if (byte_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %b want 0", byte_ready); end
    if (busy !== 1'b0)       begin errors++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    if (a !== '0)            begin errors++; $display("FAIL mid_rst_a: got %h want 0", a); end
    if (d !== 32'h0)         begin errors++; $display("FAIL mid_rst_d: got %h want 0", d); end
    if (state_dbg !== 3'd0)  begin errors++; $display("FAIL mid_rst_state: got %0d want 0", state_dbg); end
    if (done !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL mid_rst_flags: got %b%b want 00", done, error); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_start();
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h04);
`endif
    wait_end();
    exp_q.push_back({10'd0, 32'h01020304});
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL mid_nwrites: got %0d want %0d", obs_q.size(), exp_q.size());
    end else begin
      checks++;
      if (obs_q[0] !== exp_q[0]) begin errors++; $display("FAIL mid_write0: got %h want %h", obs_q[0], exp_q[0]); end
    end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL mid_done: got %b want 1", done); end
  endtask

  task automatic test_count_zero();
    do_start();
    send_byte(8'h00); send_byte(8'h00);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    wait_end();
    checks += 3;
    if (obs_q.size() != 0) begin errors++; $display("FAIL zero_nwrites: got %0d want 0", obs_q.size()); end
    if (done !== 1'b1)     begin errors++; $display("FAIL zero_done: got %b want 1", done); end
    if (busy !== 1'b0)     begin errors++; $display("FAIL zero_busy: got %b want 0", busy); end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_bad_checksum();
    do_start();
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h20); send_byte(8'h01); send_byte(8'h00); send_byte(8'h0A);
    send_byte(8'h2C);
    wait_end();
    checks += 4;
    if (error !== 1'b1)    begin errors++; $display("FAIL csum_error: got %b want 1", error); end
    if (done !== 1'b0)     begin errors++; $display("FAIL csum_done: got %b want 0", done); end
    if (obs_q.size() != 1) begin errors++; $display("FAIL csum_nwrites: got %0d want 1", obs_q.size()); end
    else if (obs_q[0] !== {10'd0, 32'h2001000A}) begin
      errors++; $display("FAIL csum_write0: got %h want %h", obs_q[0], {10'd0, 32'h2001000A});
    end
    if (busy !== 1'b0)     begin errors++; $display("FAIL csum_busy: got %b want 0", busy); end
  endtask
`endif

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_word();
    test_stall();
    test_oversize();
    test_reset_mid_word();
    test_count_zero();
`ifdef LOADER_CHECKSUM_EN
    test_bad_checksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
